// File: rtl/control_unit.sv
// Hardwired control sequencer for the simple-CPU datapath: fetch T0-T2 plus
// per-class execute steps, Moore strobes decoded from the state register.
module control_unit #(
  parameter int OPW  = 5,
  parameter int CNTW = 16
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            Run,
  input  logic [31:0]     IR,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Zin,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowout,
  output logic            ZHighout,
  output logic            LOin,
  output logic            HIin,
  output logic            Cout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [OPW-1:0]  operation,
  output logic            Done,
  output logic            Halted,
  output logic            Illegal,
  output logic [CNTW-1:0] InstrCount
);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] T0   = 4'd1;
  localparam logic [3:0] T1   = 4'd2;
  localparam logic [3:0] T2   = 4'd3;
  localparam logic [3:0] T3   = 4'd4;
  localparam logic [3:0] T4   = 4'd5;
  localparam logic [3:0] T5   = 4'd6;
  localparam logic [3:0] T6   = 4'd7;
  localparam logic [3:0] HALT = 4'd8;

  logic [3:0]      r_state;
  logic [3:0]      w_next;
  logic [3:0]      w_after;
  logic            r_illegal;
  logic [CNTW-1:0] r_count;
  logic [4:0]      w_opc;
  logic [4:0]      w_imm_op;
  logic            w_rr, w_imm, w_md, w_un, w_nop, w_halt, w_ill, w_short;
  logic            w_done;

  assign w_opc   = IR[31:27];
  assign w_rr    = (w_opc <= 5'd8);
  assign w_imm   = (w_opc >= 5'd9) && (w_opc <= 5'd11);
  assign w_md    = (w_opc == 5'd12) || (w_opc == 5'd13);
  assign w_un    = (w_opc == 5'd14) || (w_opc == 5'd15);
  assign w_nop   = (w_opc == 5'd24);
  assign w_halt  = (w_opc == 5'd25);
  assign w_ill   = !(w_rr || w_imm || w_md || w_un || w_nop || w_halt);
  assign w_short = w_nop || w_halt || w_ill;
  // Where a Done state leads: halt parks, everything else loops or idles.
  assign w_after = w_halt ? HALT : (Run ? T0 : IDLE);

  // Immediate forms map onto the plain ALU operation codes.
  always_comb begin
    case (w_opc)
      5'd9:    w_imm_op = 5'd0;
      5'd10:   w_imm_op = 5'd2;
      5'd11:   w_imm_op = 5'd3;
      default: w_imm_op = 5'd0;
    endcase
  end

  // Moore output decode of the current step.
  always_comb begin
    {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin} = 10'd0;
    {Zlowout, ZHighout, LOin, HIin, Cout, Gra, Grb, Grc, Rin, Rout} = 10'd0;
    operation = {OPW{1'b0}};
    w_done    = 1'b0;
    case (r_state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        if (w_short) w_done = 1'b1;
        else         w_done = 1'b0;
      end
      T3: begin
        if (w_un) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = OPW'(w_opc);
        end else if (w_md) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
      end
      T4: begin
        if (w_un) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_done = 1'b1;
        end else if (w_md) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = OPW'(w_opc);
        end else if (w_imm) begin
          Cout = 1'b1; Zin = 1'b1; operation = OPW'(w_imm_op);
        end else begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = OPW'(w_opc);
        end
      end
      T5: begin
        if (w_md) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_done = 1'b1;
        end
      end
      T6:      begin ZHighout = 1'b1; HIin = 1'b1; w_done = 1'b1; end
      default: begin w_done = 1'b0; end
    endcase
  end

  // Step sequencing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = Run ? T0 : IDLE;
      T0:      w_next = T1;
      T1:      w_next = T2;
      T2:      w_next = w_short ? w_after : T3;
      T3:      w_next = T4;
      T4:      w_next = w_un ? w_after : T5;
      T5:      w_next = w_md ? T6 : w_after;
      T6:      w_next = w_after;
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  // State, illegal pulse and retired-instruction counter.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_illegal <= 1'b0;
      r_count   <= {CNTW{1'b0}};
    end else begin
      r_state   <= w_next;
      r_illegal <= (r_state == T2) && w_ill;
      if (w_done && !w_ill) r_count <= r_count + {{(CNTW-1){1'b0}}, 1'b1};
      else                  r_count <= r_count;
    end
  end

  assign Done       = w_done;
  assign Halted     = (r_state == HALT);
  assign Illegal    = r_illegal;
  assign InstrCount = r_count;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-step strobe vectors, counter, illegal,
// halt, reset abort and counter wrap (on a narrow-counter second instance).
module tb_control_unit;

  localparam logic [19:0] PCOUT = 20'h80000, MARIN = 20'h40000, INCPC = 20'h20000;
  localparam logic [19:0] ZIN   = 20'h10000, PCIN  = 20'h08000, READ  = 20'h04000;
  localparam logic [19:0] MDRIN = 20'h02000, MDROUT= 20'h01000, IRIN  = 20'h00800;
  localparam logic [19:0] YIN   = 20'h00400, ZLO   = 20'h00200, ZHI   = 20'h00100;
  localparam logic [19:0] LOIN  = 20'h00080, HIIN  = 20'h00040, COUT  = 20'h00020;
  localparam logic [19:0] GRA   = 20'h00010, GRB   = 20'h00008, GRC   = 20'h00004;
  localparam logic [19:0] RIN   = 20'h00002, ROUT  = 20'h00001;
  localparam logic [19:0] S_T0  = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [19:0] S_T1  = ZLO | PCIN | READ | MDRIN;
  localparam logic [19:0] S_T2  = MDROUT | IRIN;
  localparam logic [19:0] S_WB  = ZLO | GRA | RIN;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Run = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        Run2 = 1'b0;
  logic [31:0] IR2 = 32'h0;

  logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic Zlowout, ZHighout, LOin, HIin, Cout, Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  operation;
  logic        Done, Halted, Illegal;
  logic [15:0] InstrCount;

  logic w2_PCout, w2_MARin, w2_IncPC, w2_Zin, w2_PCin, w2_Read, w2_MDRin, w2_MDRout, w2_IRin, w2_Yin;
  logic w2_Zlowout, w2_ZHighout, w2_LOin, w2_HIin, w2_Cout, w2_Gra, w2_Grb, w2_Grc, w2_Rin, w2_Rout;
  logic [4:0] w2_operation;
  logic       w2_Done, w2_Halted, w2_Illegal;
  logic [2:0] w2_InstrCount;

  logic [27:0] obs;
  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  assign obs = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
                Zlowout, ZHighout, LOin, HIin, Cout, Gra, Grb, Grc, Rin, Rout,
                operation, Done, Halted, Illegal};

  control_unit #(.OPW(5), .CNTW(16)) u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowout(Zlowout), .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .operation(operation), .Done(Done), .Halted(Halted), .Illegal(Illegal),
    .InstrCount(InstrCount)
  );

  control_unit #(.OPW(5), .CNTW(3)) u_dut_w (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run2), .IR(IR2),
    .PCout(w2_PCout), .MARin(w2_MARin), .IncPC(w2_IncPC), .Zin(w2_Zin), .PCin(w2_PCin),
    .Read(w2_Read), .MDRin(w2_MDRin), .MDRout(w2_MDRout), .IRin(w2_IRin), .Yin(w2_Yin),
    .Zlowout(w2_Zlowout), .ZHighout(w2_ZHighout), .LOin(w2_LOin), .HIin(w2_HIin), .Cout(w2_Cout),
    .Gra(w2_Gra), .Grb(w2_Grb), .Grc(w2_Grc), .Rin(w2_Rin), .Rout(w2_Rout),
    .operation(w2_operation), .Done(w2_Done), .Halted(w2_Halted), .Illegal(w2_Illegal),
    .InstrCount(w2_InstrCount)
  );

  function automatic logic [27:0] pk(input logic [19:0] s, input logic [4:0] op,
                                     input logic d, input logic h, input logic il);
    return {s, op, d, h, il};
  endfunction

  task automatic test_reset();
    #2 Reset_n = 1'b0;
    @(posedge Clock); #1;
    checks++;
    if (obs !== 28'd0) begin errors++; $display("FAIL reset_outputs got %h want %h", obs, 28'd0); end
    checks++;
    if (InstrCount !== 16'd0) begin errors++; $display("FAIL reset_count got %h want 0", InstrCount); end
    @(negedge Clock); Reset_n = 1'b1; Run = 1'b1; IR = 32'h0;
    for (int i = 0; i < 5; i++) begin @(posedge Clock); #1; end
    checks++;
    if (obs !== pk(GRC | ROUT | ZIN, 5'd0, 1'b0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset_pre_t4 got %h", obs);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 28'd0) begin errors++; $display("FAIL reset_async_abort got %h want 0", obs); end
    @(negedge Clock); Reset_n = 1'b1;
    #1;
    checks++;
    if (obs !== 28'd0) begin errors++; $display("FAIL reset_idle_after_release got %h want 0", obs); end
    @(posedge Clock); #1;
    checks++;
    if (obs !== pk(S_T0, 5'd0, 1'b0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset_t0_after_release got %h want %h", obs, pk(S_T0, 5'd0, 1'b0, 1'b0, 1'b0));
    end
    Run = 1'b0;
    #2 Reset_n = 1'b0;
    @(negedge Clock); Reset_n = 1'b1;
    #1;
    checks++;
    if (InstrCount !== 16'd0) begin errors++; $display("FAIL reset_count_after got %h want 0", InstrCount); end
  endtask

  task automatic test_rr();
    logic [27:0] exp [0:5];
    exp[0] = pk(S_T0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[1] = pk(S_T1, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[2] = pk(S_T2, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[3] = pk(GRB | ROUT | YIN, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[4] = pk(GRC | ROUT | ZIN, 5'd3, 1'b0, 1'b0, 1'b0);
    exp[5] = pk(S_WB, 5'd0, 1'b1, 1'b0, 1'b0);
    IR = 32'h1800_0000; Run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL rr_or_step%0d got %h want %h", i, obs, exp[i]); end
      if (i == 5) Run = 1'b0;
    end
    @(posedge Clock); #1;
    checks++;
    if (obs !== 28'd0) begin errors++; $display("FAIL rr_idle got %h want 0", obs); end
    checks++;
    if (InstrCount !== 16'd1) begin errors++; $display("FAIL rr_count got %0d want 1", InstrCount); end
  endtask

  task automatic test_muldiv();
    logic [27:0] exp [0:6];
    exp[0] = pk(S_T0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[1] = pk(S_T1, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[2] = pk(S_T2, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[3] = pk(GRA | ROUT | YIN, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[4] = pk(GRB | ROUT | ZIN, 5'd12, 1'b0, 1'b0, 1'b0);
    exp[5] = pk(ZLO | LOIN, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[6] = pk(ZHI | HIIN, 5'd0, 1'b1, 1'b0, 1'b0);
    IR = 32'h6000_0000; Run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL mul_step%0d got %h want %h", i, obs, exp[i]); end
      if (i == 0) Run = 1'b0;
    end
    @(posedge Clock); #1;
    checks++;
    if (obs !== 28'd0) begin errors++; $display("FAIL mul_idle got %h want 0", obs); end
    checks++;
    if (InstrCount !== 16'd2) begin errors++; $display("FAIL mul_count got %0d want 2", InstrCount); end
  endtask

  task automatic test_back_to_back();
    logic [27:0] ea [0:5];
    logic [27:0] en [0:4];
    ea[0] = pk(S_T0, 5'd0, 1'b0, 1'b0, 1'b0);
    ea[1] = pk(S_T1, 5'd0, 1'b0, 1'b0, 1'b0);
    ea[2] = pk(S_T2, 5'd0, 1'b0, 1'b0, 1'b0);
    ea[3] = pk(GRB | ROUT | YIN, 5'd0, 1'b0, 1'b0, 1'b0);
    ea[4] = pk(COUT | ZIN, 5'd2, 1'b0, 1'b0, 1'b0);
    ea[5] = pk(S_WB, 5'd0, 1'b1, 1'b0, 1'b0);
    en[0] = ea[0];
    en[1] = ea[1];
    en[2] = ea[2];
    en[3] = pk(GRB | ROUT | ZIN, 5'd14, 1'b0, 1'b0, 1'b0);
    en[4] = pk(S_WB, 5'd0, 1'b1, 1'b0, 1'b0);
    IR = 32'h5000_0000; Run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== ea[i]) begin errors++; $display("FAIL andi_step%0d got %h want %h", i, obs, ea[i]); end
    end
    IR = 32'h7000_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== en[i]) begin errors++; $display("FAIL neg_step%0d got %h want %h", i, obs, en[i]); end
      if (i == 4) Run = 1'b0;
    end
    @(posedge Clock); #1;
    checks++;
    if (obs !== 28'd0) begin errors++; $display("FAIL b2b_idle got %h want 0", obs); end
    checks++;
    if (InstrCount !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", InstrCount); end
  endtask

  task automatic test_drop_run();
    logic [27:0] exp [0:5];
    exp[0] = pk(S_T0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[1] = pk(S_T1, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[2] = pk(S_T2, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[3] = pk(GRB | ROUT | YIN, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[4] = pk(GRC | ROUT | ZIN, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[5] = pk(S_WB, 5'd0, 1'b1, 1'b0, 1'b0);
    IR = 32'h0000_0000; Run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL droprun_step%0d got %h want %h", i, obs, exp[i]); end
      if (i == 3) Run = 1'b0;
    end
    @(posedge Clock); #1;
    checks++;
    if (obs !== 28'd0) begin errors++; $display("FAIL droprun_idle got %h want 0", obs); end
    checks++;
    if (InstrCount !== 16'd5) begin errors++; $display("FAIL droprun_count got %0d want 5", InstrCount); end
  endtask

  task automatic test_illegal_halt();
    logic [27:0] exp [0:2];
    exp[0] = pk(S_T0, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[1] = pk(S_T1, 5'd0, 1'b0, 1'b0, 1'b0);
    exp[2] = pk(S_T2, 5'd0, 1'b1, 1'b0, 1'b0);
    IR = 32'hA800_0000; Run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL illegal_step%0d got %h want %h", i, obs, exp[i]); end
      if (i == 2) Run = 1'b0;
    end
    @(posedge Clock); #1;
    checks++;
    if (obs !== pk(20'd0, 5'd0, 1'b0, 1'b0, 1'b1)) begin errors++; $display("FAIL illegal_pulse got %h want %h", obs, pk(20'd0, 5'd0, 1'b0, 1'b0, 1'b1)); end
    checks++;
    if (InstrCount !== 16'd5) begin errors++; $display("FAIL illegal_count got %0d want 5", InstrCount); end
    @(posedge Clock); #1;
    checks++;
    if (obs !== 28'd0) begin errors++; $display("FAIL illegal_pulse_end got %h want 0", obs); end
    IR = 32'hC800_0000; Run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL halt_step%0d got %h want %h", i, obs, exp[i]); end
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== pk(20'd0, 5'd0, 1'b0, 1'b1, 1'b0)) begin errors++; $display("FAIL halted_cycle%0d got %h want %h", i, obs, pk(20'd0, 5'd0, 1'b0, 1'b1, 1'b0)); end
    end
    checks++;
    if (InstrCount !== 16'd6) begin errors++; $display("FAIL halt_count got %0d want 6", InstrCount); end
    Run = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({obs, InstrCount} !== 44'd0) begin errors++; $display("FAIL halt_reset got %h/%h want 0", obs, InstrCount); end
    @(negedge Clock); Reset_n = 1'b1;
  endtask

  task automatic test_wrap();
    IR2 = 32'hC000_0000; Run2 = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge Clock); #1;
      if (e == 3) begin
        checks++;
        if (w2_Done !== 1'b1) begin errors++; $display("FAIL wrap_nop_done got %b want 1", w2_Done); end
      end
      if (e == 22) begin
        checks++;
        if (w2_InstrCount !== 3'd7) begin errors++; $display("FAIL wrap_count_max got %0d want 7", w2_InstrCount); end
      end
      if (e == 25) begin
        checks++;
        if (w2_InstrCount !== 3'd0) begin errors++; $display("FAIL wrap_count_zero got %0d want 0", w2_InstrCount); end
      end
    end
    Run2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rr();
    test_muldiv();
    test_back_to_back();
    test_drop_run();
    test_illegal_halt();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
